// File: rtl/rtc_bus_responder_if.sv
// Strobe/handshake bundle for the multiplexed RTC bus.
// All strobes are active-low; the data/address byte stays a plain inout.
interface rtc_bus_responder_if;
    logic ChipSelect;
    logic Read;
    logic Write;
    logic AoD;
    logic data_oe;
    logic tick;
    logic bus_err;

    modport master (
        output ChipSelect, Read, Write, AoD,
        input  data_oe, tick, bus_err
    );

    modport slave (
        input  ChipSelect, Read, Write, AoD,
        output data_oe, tick, bus_err
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC-side responder for the multiplexed 8-bit address/data bus.
// Holds a BCD time/date with staging registers and a 1 s ripple counter.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100_000_000,
    parameter int RD_LAT   = 3
) (
    input  logic                clk,
    input  logic                Reset,
    rtc_bus_responder_if.slave  bus,
    inout  wire  [7:0]          DATA_ADDRESS
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [LW-1:0] LAT_INIT =
        LW'((RD_LAT > 3) ? RD_LAT - 4 : 0);

    // Field order: sec, min, hr, date, mon, yr, dow.
    localparam logic [6:0][7:0] TM_RST =
        {8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    localparam logic [6:0][7:0] TM_LO =
        {8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    localparam logic [6:0][7:0] TM_HI =
        {8'h07, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};

    typedef enum logic {S_IDLE, S_INCR} tstate_e;

    function automatic logic [7:0] bcd_step(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        logic [7:0] r;
        r = v;
        if (v >= hi) begin
            r = lo;
        end else if (v[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    logic cs_s1_q, cs_s2_q, rd_s1_q, rd_s2_q;
    logic wr_s1_q, wr_s2_q, aod_s1_q, aod_s2_q;
    logic rd_p_q, wr_p_q;
    logic [7:0] db_s1_q, db_s2_q;

    logic [7:0] addr_q;
    logic [6:0][7:0] tm_q, stg_q;
    logic [2:0][7:0] scr_q;

    logic oe_q, pend_q;
    logic [LW-1:0] lat_q;
    logic [7:0] rdat_q;
    logic conf_q, berr_q, dirty_q, tick_q;

    tstate_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic inc_c;

    logic conflict_c, wr_rise_c, addr_we_c, data_we_c;
    logic commit_c, rd_ok_c, rd_fall_c;
    logic tm_sel_c, sc_sel_c;
    logic [2:0] idx_c;
    logic [7:0] rdata_c, mdays_c;
    logic leap_c;
    logic [6:0][7:0] mx_c, nx_c;
    logic [4:0] wrap_c;
    logic [6:0] en_c;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cs_s1_q  <= 1'b1;
            cs_s2_q  <= 1'b1;
            rd_s1_q  <= 1'b1;
            rd_s2_q  <= 1'b1;
            wr_s1_q  <= 1'b1;
            wr_s2_q  <= 1'b1;
            aod_s1_q <= 1'b0;
            aod_s2_q <= 1'b0;
            rd_p_q   <= 1'b1;
            wr_p_q   <= 1'b1;
            db_s1_q  <= '0;
            db_s2_q  <= '0;
        end else begin
            cs_s1_q  <= bus.ChipSelect;
            cs_s2_q  <= cs_s1_q;
            rd_s1_q  <= bus.Read;
            rd_s2_q  <= rd_s1_q;
            wr_s1_q  <= bus.Write;
            wr_s2_q  <= wr_s1_q;
            aod_s1_q <= bus.AoD;
            aod_s2_q <= aod_s1_q;
            rd_p_q   <= rd_s2_q;
            wr_p_q   <= wr_s2_q;
            db_s1_q  <= DATA_ADDRESS;
            db_s2_q  <= db_s1_q;
        end
    end

    // A write strobe that overlapped a read is poisoned until it rises.
    assign conflict_c = ~cs_s2_q & ~rd_s2_q & ~wr_s2_q;
    assign wr_rise_c  = wr_s2_q & ~wr_p_q & ~cs_s2_q & ~dirty_q;
    assign addr_we_c  = wr_rise_c & ~aod_s2_q;
    assign data_we_c  = wr_rise_c & aod_s2_q;
    assign commit_c   = data_we_c & (addr_q == 8'hF1);
    assign rd_ok_c    = ~cs_s2_q & aod_s2_q & ~rd_s2_q & wr_s2_q;
    assign rd_fall_c  = rd_ok_c & rd_p_q;

    assign tm_sel_c = (addr_q >= 8'h21) && (addr_q <= 8'h27);
    assign sc_sel_c = (addr_q >= 8'h41) && (addr_q <= 8'h43);
    assign idx_c    = addr_q[2:0] - 3'd1;

    always_comb begin
        rdata_c = '0;
        unique case (1'b1)
            tm_sel_c: rdata_c = tm_q[idx_c];
            sc_sel_c: rdata_c = scr_q[idx_c[1:0]];
            default:  rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            addr_q <= '0;
            stg_q  <= TM_RST;
            scr_q  <= '0;
        end else begin
            if (addr_we_c)
                addr_q <= db_s2_q;
            if (data_we_c && tm_sel_c)
                stg_q[idx_c] <= db_s2_q;
            if (data_we_c && sc_sel_c)
                scr_q[idx_c[1:0]] <= db_s2_q;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            oe_q   <= 1'b0;
            pend_q <= 1'b0;
            lat_q  <= '0;
            rdat_q <= '0;
        end else if (!rd_ok_c) begin
            oe_q   <= 1'b0;
            pend_q <= 1'b0;
        end else if (rd_fall_c) begin
            rdat_q <= rdata_c;
            lat_q  <= LAT_INIT;
            if (RD_LAT <= 3)
                oe_q <= 1'b1;
            else
                pend_q <= 1'b1;
        end else if (pend_q) begin
            if (lat_q == '0) begin
                oe_q   <= 1'b1;
                pend_q <= 1'b0;
            end else begin
                lat_q <= lat_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            conf_q  <= 1'b0;
            berr_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            conf_q <= conflict_c;
            berr_q <= conflict_c & ~conf_q;
            if (conflict_c)
                dirty_q <= 1'b1;
            else if (wr_s2_q)
                dirty_q <= 1'b0;
        end
    end

    // Feb length: BCD year divisible by 4 iff (2*tens + units) % 4 == 0.
    assign leap_c = (tm_q[5][1:0] + {tm_q[5][4], 1'b0}) == 2'b00;

    always_comb begin
        mdays_c = 8'h31;
        unique case (tm_q[4])
            8'h02:                      mdays_c = leap_c ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: mdays_c = 8'h30;
            default:                    mdays_c = 8'h31;
        endcase
    end

    always_comb begin
        mx_c    = TM_HI;
        mx_c[3] = mdays_c;
        nx_c    = tm_q;
        wrap_c  = '0;
        for (int i = 0; i < 7; i++)
            nx_c[i] = bcd_step(tm_q[i], TM_LO[i], mx_c[i]);
        for (int i = 0; i < 5; i++)
            wrap_c[i] = tm_q[i] >= mx_c[i];
        en_c[0] = 1'b1;
        en_c[1] = wrap_c[0];
        en_c[2] = en_c[1] & wrap_c[1];
        en_c[3] = en_c[2] & wrap_c[2];
        en_c[4] = en_c[3] & wrap_c[3];
        en_c[5] = en_c[4] & wrap_c[4];
        en_c[6] = en_c[3];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        inc_c   = 1'b0;
        unique case (state_q)
            S_IDLE: if (cnt_q == LAST) state_d = S_INCR;
            S_INCR: begin
                state_d = S_IDLE;
                inc_c   = 1'b1;
            end
        endcase
        // A commit always beats a pending increment.
        if (commit_c) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            inc_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            tm_q    <= TM_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= inc_c;
            if (commit_c) begin
                tm_q <= stg_q;
            end else if (inc_c) begin
                for (int i = 0; i < 7; i++)
                    if (en_c[i]) tm_q[i] <= nx_c[i];
            end
        end
    end

    assign DATA_ADDRESS = oe_q ? rdat_q : 8'hzz;
    assign bus.data_oe  = oe_q;
    assign bus.tick     = tick_q;
    assign bus.bus_err  = berr_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder: reads push expected bytes,
// a monitor pops and compares them when data_oe rises.
module tb_rtc_bus_responder;

    localparam int TD = 400;

    logic clk = 1'b0;
    logic Reset;
    logic tb_oe;
    logic [7:0] tb_d;
    wire  [7:0] da;

    rtc_bus_responder_if bif();

    assign da = tb_oe ? tb_d : 8'hzz;

    rtc_bus_responder #(.TICK_DIV(TD), .RD_LAT(3)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .bus          (bif),
        .DATA_ADDRESS (da)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cyc = 0;
    int tick_n = 0;
    int tick_cyc = 0;
    int err_n = 0;
    logic oe_prev = 1'b0;
    logic [7:0] expq[$];
    logic [7:0] tagq[$];
    logic [7:0] e_v, a_v;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bif.tick) begin
            tick_n++;
            tick_cyc = cyc;
        end
        if (bif.bus_err) err_n++;
        if (bif.data_oe && !oe_prev) begin
            if (expq.size() == 0) begin
                chk("unexp_oe", 1, 0);
            end else begin
                e_v = expq.pop_front();
                a_v = tagq.pop_front();
                chk($sformatf("rd%02h", a_v), da, e_v);
                chk("rd_lat", cyc - rd_cyc, 3);
            end
        end
        oe_prev = bif.data_oe;
    end

    task automatic bus_wr(input logic aod, input logic [7:0] d);
        @(negedge clk);
        bif.ChipSelect = 1'b0;
        bif.AoD = aod;
        tb_oe = 1'b1;
        tb_d = d;
        @(negedge clk);
        bif.Write = 1'b0;
        repeat (3) @(negedge clk);
        bif.Write = 1'b1;
        repeat (3) @(negedge clk);
        bif.ChipSelect = 1'b1;
        tb_oe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic stg(input logic [7:0] a, input logic [7:0] v);
        bus_wr(1'b0, a);
        bus_wr(1'b1, v);
    endtask

    task automatic rd_start(input logic [7:0] a, input logic [7:0] e);
        bus_wr(1'b0, a);
        @(negedge clk);
        bif.ChipSelect = 1'b0;
        bif.AoD = 1'b1;
        @(negedge clk);
        bif.Read = 1'b0;
        rd_cyc = cyc;
        expq.push_back(e);
        tagq.push_back(a);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        rd_start(a, e);
        repeat (6) @(negedge clk);
        bif.Read = 1'b1;
        bif.ChipSelect = 1'b1;
        repeat (4) @(negedge clk);
        chk("oe_off", bif.data_oe, 0);
        chk("rd_done", expq.size(), 0);
    endtask

    task automatic wait_tick();
        int n0;
        n0 = tick_n;
        for (int i = 0; i < TD + 20; i++) begin
            if (tick_n != n0) break;
            @(negedge clk);
        end
        chk("tick_seen", int'(tick_n != n0), 1);
    endtask

    int n_tk;
    int e0;
    int tgt;

    initial begin
        Reset = 1'b0;
        bif.ChipSelect = 1'b1;
        bif.Read = 1'b1;
        bif.Write = 1'b1;
        bif.AoD = 1'b0;
        tb_oe = 1'b0;
        tb_d = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_oe", bif.data_oe, 0);
        chk("rst_tick", bif.tick, 0);
        chk("rst_berr", bif.bus_err, 0);
        Reset = 1'b1;

        // reset in the middle of a driven read
        rd_start(8'h41, 8'h00);
        repeat (5) @(negedge clk);
        chk("pre_rst_oe", bif.data_oe, 1);
        Reset = 1'b0;
        #1;
        chk("rst_async_oe", bif.data_oe, 0);
        bif.Read = 1'b1;
        bif.ChipSelect = 1'b1;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        rd(8'h21, 8'h00);
        rd(8'h24, 8'h01);

        // scratch, unmapped, abort
        stg(8'h41, 8'h5A);
        rd(8'h41, 8'h5A);
        stg(8'h42, 8'hA5);
        rd(8'h42, 8'hA5);
        rd(8'h30, 8'h00);
        stg(8'h30, 8'hFF);
        rd(8'h30, 8'h00);
        bus_wr(1'b0, 8'h42);
        @(negedge clk);
        bif.ChipSelect = 1'b0;
        bif.AoD = 1'b1;
        tb_oe = 1'b1;
        tb_d = 8'h77;
        @(negedge clk);
        bif.Write = 1'b0;
        repeat (3) @(negedge clk);
        bif.ChipSelect = 1'b1;
        repeat (3) @(negedge clk);
        bif.Write = 1'b1;
        tb_oe = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h42, 8'hA5);

        // read/write conflict
        bus_wr(1'b0, 8'h41);
        e0 = err_n;
        @(negedge clk);
        bif.ChipSelect = 1'b0;
        bif.AoD = 1'b1;
        tb_oe = 1'b1;
        tb_d = 8'h33;
        @(negedge clk);
        bif.Write = 1'b0;
        bif.Read = 1'b0;
        repeat (6) @(negedge clk);
        bif.Write = 1'b1;
        repeat (4) @(negedge clk);
        bif.Read = 1'b1;
        repeat (3) @(negedge clk);
        bif.ChipSelect = 1'b1;
        tb_oe = 1'b0;
        repeat (3) @(negedge clk);
        chk("berr_cnt", err_n - e0, 1);
        rd(8'h41, 8'h5A);

        // end of Feb, non-leap year
        stg(8'h21, 8'h59);
        stg(8'h22, 8'h59);
        stg(8'h23, 8'h23);
        stg(8'h24, 8'h28);
        stg(8'h25, 8'h02);
        stg(8'h26, 8'h23);
        stg(8'hF1, 8'h00);
        wait_tick();
        rd(8'h21, 8'h00);
        rd(8'h22, 8'h00);
        rd(8'h23, 8'h00);
        rd(8'h24, 8'h01);
        rd(8'h25, 8'h03);
        rd(8'h26, 8'h23);
        rd(8'h27, 8'h02);

        // end of Feb 28, leap year
        stg(8'h26, 8'h24);
        stg(8'hF1, 8'h00);
        wait_tick();
        rd(8'h21, 8'h00);
        rd(8'h24, 8'h29);
        rd(8'h25, 8'h02);
        rd(8'h26, 8'h24);
        rd(8'h27, 8'h02);

        // commit lands in the tick-due cycle
        wait_tick();
        tgt = tick_cyc + TD - 4;
        n_tk = tick_n;
        bus_wr(1'b0, 8'hF1);
        @(negedge clk);
        bif.ChipSelect = 1'b0;
        bif.AoD = 1'b1;
        tb_oe = 1'b1;
        tb_d = 8'h00;
        @(negedge clk);
        bif.Write = 1'b0;
        while (cyc < tgt) @(negedge clk);
        bif.Write = 1'b1;
        repeat (3) @(negedge clk);
        bif.ChipSelect = 1'b1;
        tb_oe = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_tick", tick_n - n_tk, 0);
        rd(8'h21, 8'h59);
        rd(8'h23, 8'h23);
        rd(8'h24, 8'h28);
        rd(8'h27, 8'h01);

        chk("q_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
